simon_key_r_iter: RTL and testbench

Iterative reverse key-schedule generator for Simon 32/64 decryption. It is loaded with the last four round keys (k28..k31) and emits all 32 round keys in descending order, k31 down to k0, one per accepted handshake. It inverts the forward recurrence, so the decryption datapath needs no stored key table. It pairs with the combinational forward key expansion, which produces k0..k31 ascending.

---
 rtl/simon_key_r_iter.sv | 123 ++++++++++++
 tb/tb_simon_key_r_iter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_r_iter.sv
// Iterative reverse key schedule for Simon 32/64: loaded with k28..k31, it emits k31 down to k0
// one key per valid/ready handshake by inverting the forward key recurrence.
module simon_key_r_iter #(
   parameter logic [15:0] C_CONST = 16'hfffc,
   parameter logic [61:0] Z_SEQ   =
      62'b01100111000011010100100010111110110011100001101010010001011111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [63:0] tail_keys,
   input  logic        key_ready,
   output logic        key_valid,
   output logic [15:0] key_out,
   output logic [4:0]  key_idx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StTail, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [15:0] w0_q, w1_q, w2_q, w3_q;
   logic [15:0] w0_d, w1_d, w2_d, w3_d;
   logic [15:0] t, f, k_run, k_tail;
   logic        xfer;

   // Inverse round: window holds k[idx+1..idx+4], so k[idx] is recovered from w3 and f(w0, w2).
   always_comb begin
      t     = {w2_q[2:0], w2_q[15:3]} ^ w0_q;
      f     = t ^ {t[0], t[15:1]};
      k_run = w3_q ^ f ^ C_CONST ^ {15'b0, Z_SEQ[idx_q]};
   end

   // In the tail phase idx is 31..28, so its low two bits select w3..w0.
   always_comb begin
      unique case (idx_q[1:0])
         2'd3:    k_tail = w3_q;
         2'd2:    k_tail = w2_q;
         2'd1:    k_tail = w1_q;
         default: k_tail = w0_q;
      endcase
   end

   always_comb begin
      key_valid = (state_q == StTail) || (state_q == StRun);
      busy      = key_valid;
      done      = (state_q == StDone);
      key_idx   = key_valid ? idx_q : 5'd0;
      key_out   = 16'd0;
      if (state_q == StTail) begin
         key_out = k_tail;
      end else if (state_q == StRun) begin
         key_out = k_run;
      end
   end

   assign xfer = key_valid && key_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      w2_d    = w2_q;
      w3_d    = w3_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               w0_d    = tail_keys[63:48];
               w1_d    = tail_keys[47:32];
               w2_d    = tail_keys[31:16];
               w3_d    = tail_keys[15:0];
               idx_d   = 5'd31;
               state_d = StTail;
            end
         end
         StTail: begin
            if (xfer) begin
               idx_d = idx_q - 5'd1;
               if (idx_q == 5'd28) begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (xfer) begin
               w3_d = w2_q;
               w2_d = w1_q;
               w1_d = w0_q;
               w0_d = k_run;
               if (idx_q == 5'd0) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q - 5'd1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 5'd0;
         w0_q    <= 16'd0;
         w1_q    <= 16'd0;
         w2_q    <= 16'd0;
         w3_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         w2_q    <= w2_d;
         w3_q    <= w3_d;
      end
   end

endmodule

// File: tb/tb_simon_key_r_iter.sv
// Bench for simon_key_r_iter: two instances (standard z0 and all-zero z) share stimulus and are
// checked against an array model of the Simon 32/64 key schedule.
module tb_simon_key_r_iter;

   localparam logic [15:0] C    = 16'hfffc;
   localparam logic [61:0] ZSEQ =
      62'b01100111000011010100100010111110110011100001101010010001011111;
   localparam logic [61:0] ZNUL = 62'd0;

   logic        clk = 1'b0;
   logic        rst, start, key_ready;
   logic [63:0] tail_keys;
   logic        key_valid_a, busy_a, done_a, key_valid_b, busy_b, done_b;
   logic [15:0] key_out_a, key_out_b;
   logic [4:0]  key_idx_a, key_idx_b;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_a [32];
   logic [15:0] exp_b [32];
   logic [15:0] got_a [32];
   logic [15:0] got_b [32];
   logic [15:0] fwd   [32];
   logic [63:0] tail_fwd;

   simon_key_r_iter #(.C_CONST(C), .Z_SEQ(ZSEQ)) dut_a (
      .clk(clk), .rst(rst), .start(start), .tail_keys(tail_keys), .key_ready(key_ready),
      .key_valid(key_valid_a), .key_out(key_out_a), .key_idx(key_idx_a), .busy(busy_a),
      .done(done_a)
   );

   simon_key_r_iter #(.C_CONST(C), .Z_SEQ(ZNUL)) dut_b (
      .clk(clk), .rst(rst), .start(start), .tail_keys(tail_keys), .key_ready(key_ready),
      .key_valid(key_valid_b), .key_out(key_out_b), .key_idx(key_idx_b), .busy(busy_b),
      .done(done_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [15:0] ror(input logic [15:0] x, input int n);
      return (x >> n) | (x << (16 - n));
   endfunction

   // Forward Simon 32/64 expansion of a 64-bit master key (k0 in the low word).
   task automatic build_forward(input logic [63:0] mk);
      logic [15:0] tt;
      for (int j = 0; j < 4; j++) fwd[j] = mk[16*j +: 16];
      for (int i = 0; i < 28; i++) begin
         tt         = ror(fwd[i+3], 3) ^ fwd[i+1];
         fwd[i + 4] = ~fwd[i] ^ tt ^ ror(tt, 1) ^ {15'd0, ZSEQ[i]} ^ 16'd3;
      end
   endtask

   // Solve k[i+4] = k[i] ^ f ^ c ^ z[i] for k[i], walking down from the loaded tail.
   task automatic build_model(input logic [63:0] tail);
      logic [15:0] tt;
      for (int j = 0; j < 4; j++) begin
         exp_a[28 + j] = tail[63 - 16*j -: 16];
         exp_b[28 + j] = tail[63 - 16*j -: 16];
      end
      for (int i = 27; i >= 0; i--) begin
         tt       = ror(exp_a[i+3], 3) ^ exp_a[i+1];
         exp_a[i] = exp_a[i+4] ^ tt ^ ror(tt, 1) ^ C ^ {15'd0, ZSEQ[i]};
         tt       = ror(exp_b[i+3], 3) ^ exp_b[i+1];
         exp_b[i] = exp_b[i+4] ^ tt ^ ror(tt, 1) ^ C;
      end
   endtask

   // Runs one full sequence from IDLE; returns one cycle after the DONE pulse (back in IDLE).
   task automatic run_seq(input logic [63:0] tail, input bit rand_ready, input bit poke);
      int          n, cyc, e;
      bit          have_prev;
      logic [15:0] prev_key;
      logic [4:0]  prev_idx;
      build_model(tail);
      tail_keys = tail;
      start     = 1'b1;
      key_ready = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      tail_keys = ~tail;
      n = 0; cyc = 0; have_prev = 0;
      prev_key = '0; prev_idx = '0;
      while (n < 32 && cyc < 300) begin
         e = 31 - n;
         chk("valid", 32'(key_valid_a), 32'd1);
         chk("busy", 32'(busy_a), 32'd1);
         chk("done_early", 32'(done_a), 32'd0);
         chk($sformatf("idx_a@%0d", e), 32'(key_idx_a), 32'(e));
         chk($sformatf("idx_b@%0d", e), 32'(key_idx_b), 32'(e));
         chk($sformatf("key_a@%0d", e), 32'(key_out_a), 32'(exp_a[e]));
         chk($sformatf("key_b@%0d", e), 32'(key_out_b), 32'(exp_b[e]));
         if (have_prev) begin
            chk("stall_key", 32'(key_out_a), 32'(prev_key));
            chk("stall_idx", 32'(key_idx_a), 32'(prev_idx));
         end
         got_a[e]  = key_out_a;
         got_b[e]  = key_out_b;
         prev_key  = key_out_a;
         prev_idx  = key_idx_a;
         key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke && e == 15) begin
            start     = 1'b1;
            tail_keys = {$urandom, $urandom};
         end
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         if (key_ready) begin
            n++;
            have_prev = 0;
         end else begin
            have_prev = 1;
         end
      end
      chk("seq_complete", 32'(n), 32'd32);
      chk("done_pulse_a", 32'(done_a), 32'd1);
      chk("done_pulse_b", 32'(done_b), 32'd1);
      chk("done_valid", 32'(key_valid_a), 32'd0);
      chk("done_busy", 32'(busy_a), 32'd0);
      start     = poke;
      tail_keys = {$urandom, $urandom};
      key_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("idle_done", 32'(done_a), 32'd0);
      chk("idle_valid", 32'(key_valid_a), 32'd0);
      chk("idle_busy", 32'(busy_a), 32'd0);
   endtask

   initial begin
      int cyc;
      rst       = 1'b1;
      start     = 1'b0;
      key_ready = 1'b1;
      tail_keys = '0;
      #12;
      chk("rst_valid", 32'(key_valid_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_key", 32'(key_out_a), 32'd0);
      chk("rst_idx", 32'(key_idx_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_valid", 32'(key_valid_a), 32'd0);

      // Round trip against the forward expansion.
      build_forward(64'h1918111009080100);
      tail_fwd = {fwd[28], fwd[29], fwd[30], fwd[31]};
      run_seq(tail_fwd, 1'b0, 1'b0);
      for (int i = 0; i < 32; i++) chk($sformatf("rt_k%0d", i), 32'(got_a[i]), 32'(fwd[i]));
      chk("rt_k0", 32'(got_a[0]), 32'h0100);
      chk("rt_k1", 32'(got_a[1]), 32'h0908);
      chk("rt_k2", 32'(got_a[2]), 32'h1110);
      chk("rt_k3", 32'(got_a[3]), 32'h1918);

      // Backpressure, then ignored start mid-run and in DONE.
      run_seq(tail_fwd, 1'b1, 1'b0);
      for (int i = 0; i < 32; i++) chk($sformatf("bp_k%0d", i), 32'(got_a[i]), 32'(fwd[i]));
      run_seq(tail_fwd, 1'b1, 1'b1);
      for (int i = 0; i < 32; i++) chk($sformatf("ign_k%0d", i), 32'(got_a[i]), 32'(fwd[i]));

      // Asynchronous reset mid-run at key_idx 20.
      tail_keys = tail_fwd;
      start     = 1'b1;
      key_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 0;
      while (key_idx_a != 5'd20 && cyc < 64) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reach_idx20", 32'(key_idx_a), 32'd20);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(key_valid_a), 32'd0);
      chk("arst_busy", 32'(busy_a), 32'd0);
      chk("arst_done", 32'(done_a), 32'd0);
      chk("arst_key", 32'(key_out_a), 32'd0);
      chk("arst_idx", 32'(key_idx_a), 32'd0);
      chk("arst_valid_b", 32'(key_valid_b), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         chk("arst_idle_valid", 32'(key_valid_a), 32'd0);
         chk("arst_idle_busy", 32'(busy_a), 32'd0);
      end

      // Random tails with random backpressure.
      repeat (3) run_seq({$urandom, $urandom}, 1'b1, 1'b0);

      // Back-to-back: second start lands on the first edge after DONE.
      run_seq({$urandom, $urandom}, 1'b0, 1'b0);
      run_seq(64'd0, 1'b0, 1'b0);
      for (int j = 28; j < 32; j++) chk($sformatf("zero_k%0d", j), 32'(got_a[j]), 32'd0);
      chk("b2b_k27", 32'(got_a[27]), 32'(C ^ {15'd0, ZSEQ[27]}));
      chk("zeroz_k27", 32'(got_b[27]), 32'(C));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
